// File: rtl/data_memory_split.sv
// data_memory_split: byte-addressable dual-port data memory.
//   Port A: processor 1/2/4-byte little-endian loads/stores. Accesses that
//           straddle a word boundary take two RAM cycles (FIRST, SECOND).
//   Port B: read-only VGA word port (pixel byte + image dimensions).
//   While proc_en=0, port A is used to mirror the quadrant code into RAM.
// Optional build macro: DMEM_FWD_EN forwards same-cycle port-A writes to
// the port-B read data; without it port B returns the pre-write word.
module data_memory_split #(
    parameter int ADDR_W     = 19,
    parameter int WORD_BYTES = 4,
    parameter int QUAD_ADDR  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    proc_en,
    input  logic [3:0]              cuadrante,
    input  logic                    req,
    input  logic                    we,
    input  logic [1:0]              size,
    input  logic [ADDR_W-1:0]       A,
    input  logic [8*WORD_BYTES-1:0] WD,
    output logic [8*WORD_BYTES-1:0] RD,
    output logic                    ready,
    output logic                    busy,
    input  logic [ADDR_W-1:0]       DataAdr_VGA,
    output logic [7:0]              pixel,
    output logic [15:0]             dimensiones
);

    localparam int LOG2WB = $clog2(WORD_BYTES);
    localparam int IW     = ADDR_W - LOG2WB;
    localparam int DEPTH  = 1 << IW;
    localparam int DW     = 8 * WORD_BYTES;
    localparam logic [IW-1:0] QIDX = IW'(QUAD_ADDR >> LOG2WB);
    localparam int QLANE  = QUAD_ADDR % WORD_BYTES;

    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND, S_DONE} state_t;

    logic [DW-1:0] r_mem [DEPTH];

    state_t            r_state;
    logic [ADDR_W-1:0] r_a;
    logic              r_we;
    logic [1:0]        r_size;
    logic [DW-1:0]     r_wd;
    logic [DW-1:0]     r_acc;
    logic [3:0]        r_quad_q;
    logic              r_quad_pend;

    int                w_off;
    int                w_nb;
    logic              w_cross;
    logic [IW-1:0]     w_idx;
    logic [DW-1:0]     w_rword;
    logic [WORD_BYTES-1:0] w_be;
    logic [DW-1:0]     w_wbytes;
    logic [DW-1:0]     w_rbytes;
    logic              w_quad_wr;
    logic              w_wr_en;
    logic [IW-1:0]     w_wr_idx;
    logic [WORD_BYTES-1:0] w_wr_be;
    logic [DW-1:0]     w_wr_data;
    logic [IW-1:0]     w_vga_idx;
    logic [LOG2WB-1:0] w_vga_lane;
    logic [DW-1:0]     w_vga_word;

    // Offset/size decode of the captured request; size 3 behaves like 2,
    // and an access never spans more than two words.
    always_comb begin
        w_off = int'(r_a[LOG2WB-1:0]);
        w_nb  = (r_size == 2'd0) ? 1 : (r_size == 2'd1) ? 2 : 4;
        if (w_nb > WORD_BYTES) w_nb = WORD_BYTES;
        w_cross = (w_off + w_nb) > WORD_BYTES;
    end

    // FIRST uses the request's word, SECOND the next one (wraps naturally).
    assign w_idx   = r_a[ADDR_W-1:LOG2WB] + {{(IW-1){1'b0}}, (r_state == S_SECOND)};
    assign w_rword = r_mem[w_idx];

    // Map RAM lane j to request byte k for the current half of the access.
    always_comb begin
        int k;
        k        = 0;
        w_be     = '0;
        w_wbytes = '0;
        w_rbytes = '0;
        for (int j = 0; j < WORD_BYTES; j++) begin
            k = (r_state == S_SECOND) ? (j + WORD_BYTES - w_off) : (j - w_off);
            if (k >= 0 && k < w_nb) begin
                w_be[j]            = 1'b1;
                w_wbytes[8*j +: 8] = r_wd[8*k +: 8];
                w_rbytes[8*k +: 8] = w_rword[8*j +: 8];
            end
        end
    end

    // Quadrant mirror only runs while the processor is parked and idle.
    assign w_quad_wr = (r_state == S_IDLE) && !proc_en && r_quad_pend;

    // Single RAM write port: quadrant writer or processor store half.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = w_idx;
        w_wr_be   = w_be;
        w_wr_data = w_wbytes;
        if (w_quad_wr) begin
            w_wr_en        = 1'b1;
            w_wr_idx       = QIDX;
            w_wr_be        = '0;
            w_wr_be[QLANE] = 1'b1;
            w_wr_data      = {WORD_BYTES{{4'h0, cuadrante}}};
        end else if (r_we && (r_state == S_FIRST || r_state == S_SECOND)) begin
            w_wr_en = 1'b1;
        end
        // RAM has no reset of its own; keep it untouched while reset is held.
        if (reset) w_wr_en = 1'b0;
    end

    // RAM byte-lane writes (contents deliberately not reset).
    always_ff @(posedge clk) begin
        for (int j = 0; j < WORD_BYTES; j++)
            if (w_wr_en && w_wr_be[j])
                r_mem[w_wr_idx][8*j +: 8] <= w_wr_data[8*j +: 8];
    end

    assign w_vga_idx  = DataAdr_VGA[ADDR_W-1:LOG2WB];
    assign w_vga_lane = DataAdr_VGA[LOG2WB-1:0];

`ifdef DMEM_FWD_EN
    // Merge this cycle's port-A write into the port-B read word.
    always_comb begin
        w_vga_word = r_mem[w_vga_idx];
        if (w_wr_en && (w_wr_idx == w_vga_idx))
            for (int j = 0; j < WORD_BYTES; j++)
                if (w_wr_be[j]) w_vga_word[8*j +: 8] = w_wr_data[8*j +: 8];
    end
`else
    assign w_vga_word = r_mem[w_vga_idx];
`endif

    // Port B registered read: pixel byte and dimensions half-word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel       <= '0;
            dimensiones <= '0;
        end else begin
            pixel       <= w_vga_word[8*w_vga_lane +: 8];
            dimensiones <= w_vga_word[15:0];
        end
    end

    // Port-A access FSM plus quadrant pending tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_we        <= 1'b0;
            r_size      <= '0;
            r_wd        <= '0;
            r_acc       <= '0;
            r_quad_q    <= '0;
            r_quad_pend <= 1'b1;
            RD          <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_quad_pend <= w_quad_wr ? 1'b0 : (r_quad_pend || (cuadrante != r_quad_q));
            if (w_quad_wr) r_quad_q <= cuadrante;
            case (r_state)
                S_IDLE: begin
                    if (req && proc_en) begin
                        r_a     <= A;
                        r_we    <= we;
                        r_size  <= size;
                        r_wd    <= WD;
                        busy    <= 1'b1;
                        r_state <= S_FIRST;
                    end
                end
                S_FIRST: begin
                    if (w_cross) begin
                        r_acc   <= w_rbytes;
                        r_state <= S_SECOND;
                    end else begin
                        RD      <= r_we ? '0 : w_rbytes;
                        ready   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_SECOND: begin
                    RD      <= r_we ? '0 : (r_acc | w_rbytes);
                    ready   <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    RD      <= '0;
                    ready   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
